// File: rtl/l1_biu_seq_pkg.sv
// ---------------------------------------------------------------------------
// l1_biu_pkg
// Shared constants for the L1 instruction-cache bus-interface sequencer.
//   - State encoding (IDLE..ERR), kept as plain localparams so the values
//     line up with the existing cache-side debug decode.
//   - Request-kind encoding (KIND_LINE / KIND_RD / KIND_WR).
//   - Default line-size exponent.
//   - pick_kind(): fixed-priority request arbitration used in IDLE.
// ---------------------------------------------------------------------------
package l1_biu_pkg;

  localparam int DEF_LINE_WID = 8;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LINE = 3'd1;
  localparam logic [2:0] RD   = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] DONE = 3'd4;
  localparam logic [2:0] ERR  = 3'd5;

  localparam logic [1:0] KIND_NONE = 2'd0;
  localparam logic [1:0] KIND_LINE = 2'd1;
  localparam logic [1:0] KIND_RD   = 2'd2;
  localparam logic [1:0] KIND_WR   = 2'd3;

  // Line refill beats uncached read, which beats write-through.
  function automatic logic [1:0] pick_kind(input logic line_req,
                                           input logic rd_req,
                                           input logic wr_req);
    logic [1:0] kind;
    if (line_req) begin
      kind = KIND_LINE;
    end else if (rd_req) begin
      kind = KIND_RD;
    end else if (wr_req) begin
      kind = KIND_WR;
    end else begin
      kind = KIND_NONE;
    end
    return kind;
  endfunction

endpackage

// File: rtl/l1_biu_seq_if.sv
// ---------------------------------------------------------------------------
// l1_biu_seq_if
// Byte-wide req/ack memory bus between the L1 sequencer and the SoC bus.
//   bus_req    beat request (held stable until ack or err)
//   bus_we     1 = write beat
//   bus_addr   beat address
//   bus_wdata  write data
//   bus_rdata  read data, valid with bus_ack
//   bus_ack    beat completed
//   bus_err    beat failed; wins over bus_ack in the same cycle
// Modports: master = sequencer side, slave = memory side.
// ---------------------------------------------------------------------------
interface l1_biu_seq_if #(
  parameter int ADDR_WIDTH = 24
);

  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [7:0]            bus_wdata;
  logic [7:0]            bus_rdata;
  logic                  bus_ack;
  logic                  bus_err;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    input  bus_rdata,
    input  bus_ack,
    input  bus_err
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    output bus_rdata,
    output bus_ack,
    output bus_err
  );

endinterface

// File: rtl/l1_biu_seq_watchdog.sv
// ---------------------------------------------------------------------------
// l1_biu_watchdog
// Per-beat wait counter. Counts cycles while enable is high, saturating at
// TIMEOUT_CYC; clear returns it to zero. expire is high while the count sits
// at TIMEOUT_CYC, the beat is still pending and no clear is present.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   clear     restart counting (new beat / ack / bus idle)
//   enable    a beat is outstanding
//   expire    beat has waited TIMEOUT_CYC cycles
// ---------------------------------------------------------------------------
module l1_biu_watchdog #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC);

  logic [CW-1:0] cnt_r;

  // Wait counter: cleared on request, saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (clear) begin
      cnt_r <= {CW{1'b0}};
    end else if (enable && (cnt_r != LIMIT)) begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire = enable & ~clear & (cnt_r == LIMIT);

endmodule

// File: rtl/l1_biu_seq.sv
// ---------------------------------------------------------------------------
// l1_biu_seq
// Bus-interface sequencer behind the direct-mapped L1 instruction cache.
// Runs line refills, single uncached reads and single write-throughs over a
// byte-wide req/ack bus and produces the strobes the line-fill datapath uses.
//
// Optional feature macro: L1_BIU_TIMEOUT_EN
//   defined   -> a beat waiting TIMEOUT_CYC cycles without ack aborts as if
//                bus_err had been seen (l1_biu_watchdog instantiated)
//   undefined -> the sequencer waits indefinitely for ack/err
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   read_line_req        request a line refill (base = pa, low bits zeroed)
//   read_req             request one uncached byte read at pa
//   write_through_req    request one byte write of wt_data at pa
//   pa, wt_data          request address / write data (sampled in IDLE)
//   line_data            registered read data to the cache
//   addr_count           byte index of the beat on line_data
//   line_write           cache writes line_data at addr_count this cycle
//   cache_entry_refill   pulse: tag of the refilled line becomes valid
//   trans_rdy            pulse: transaction completed
//   bus_error            pulse: transaction aborted
//   busy                 sequencer not in IDLE
//   bus                  memory bus (master modport)
// ---------------------------------------------------------------------------
module l1_biu_seq
  import l1_biu_pkg::*;
#(
  parameter int ADDR_WIDTH  = 24,
  parameter int LINE_WID    = DEF_LINE_WID,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_line_req,
  input  logic                  read_req,
  input  logic                  write_through_req,
  input  logic [ADDR_WIDTH-1:0] pa,
  input  logic [7:0]            wt_data,
  output logic [7:0]            line_data,
  output logic [LINE_WID-1:0]   addr_count,
  output logic                  line_write,
  output logic                  cache_entry_refill,
  output logic                  trans_rdy,
  output logic                  bus_error,
  output logic                  busy,
  l1_biu_seq_if.master          bus
);

  localparam logic [LINE_WID-1:0] BEAT_ZERO = {LINE_WID{1'b0}};
  localparam logic [LINE_WID-1:0] BEAT_LAST = {LINE_WID{1'b1}};
  localparam logic [LINE_WID-1:0] BEAT_ONE  = {{(LINE_WID-1){1'b0}}, 1'b1};

  logic [2:0]            state_r;
  logic [ADDR_WIDTH-1:0] base_r;
  logic [7:0]            wdata_r;
  logic [LINE_WID-1:0]   beat_r;
  logic [7:0]            line_data_r;
  logic [LINE_WID-1:0]   addr_count_r;
  logic                  line_write_r;
  logic                  refill_r;
  logic                  trans_rdy_r;
  logic                  bus_error_r;
  logic                  busy_r;
  logic                  bus_req_r;
  logic                  bus_we_r;
  logic [ADDR_WIDTH-1:0] bus_addr_r;
  logic [7:0]            bus_wdata_r;

  logic [1:0]            req_kind_s;
  logic                  timeout_s;
  logic                  fail_s;
  logic                  ack_s;
  logic [LINE_WID-1:0]   beat_nxt_s;
  logic [ADDR_WIDTH-1:0] line_base_s;

  assign req_kind_s  = pick_kind(read_line_req, read_req, write_through_req);
  // bus_err (or a timeout) always wins over a same-cycle ack.
  assign fail_s      = bus.bus_err | timeout_s;
  assign ack_s       = bus.bus_ack & ~fail_s;
  assign beat_nxt_s  = beat_r + BEAT_ONE;
  assign line_base_s = {pa[ADDR_WIDTH-1:LINE_WID], BEAT_ZERO};

`ifdef L1_BIU_TIMEOUT_EN
  logic wd_clear_s;

  // A new beat is always either the first one (bus_req was low) or follows
  // an ack, so these two terms restart the count for every beat.
  assign wd_clear_s = bus.bus_ack | ~bus_req_r;

  l1_biu_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear_s),
    .enable (bus_req_r),
    .expire (timeout_s)
  );
`else
  logic unused_timeout_s;

  assign timeout_s        = 1'b0;
  assign unused_timeout_s = (TIMEOUT_CYC == 0);
`endif

  // Sequencer FSM with all outputs registered; pulses default low each cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      base_r       <= {ADDR_WIDTH{1'b0}};
      wdata_r      <= 8'h00;
      beat_r       <= BEAT_ZERO;
      line_data_r  <= 8'h00;
      addr_count_r <= BEAT_ZERO;
      line_write_r <= 1'b0;
      refill_r     <= 1'b0;
      trans_rdy_r  <= 1'b0;
      bus_error_r  <= 1'b0;
      busy_r       <= 1'b0;
      bus_req_r    <= 1'b0;
      bus_we_r     <= 1'b0;
      bus_addr_r   <= {ADDR_WIDTH{1'b0}};
      bus_wdata_r  <= 8'h00;
    end else begin
      line_write_r <= 1'b0;
      refill_r     <= 1'b0;
      trans_rdy_r  <= 1'b0;
      bus_error_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          beat_r <= BEAT_ZERO;
          case (req_kind_s)
            KIND_LINE: begin
              state_r     <= LINE;
              base_r      <= line_base_s;
              wdata_r     <= wt_data;
              busy_r      <= 1'b1;
              bus_req_r   <= 1'b1;
              bus_we_r    <= 1'b0;
              bus_addr_r  <= line_base_s;
              bus_wdata_r <= 8'h00;
            end
            KIND_RD: begin
              state_r     <= RD;
              base_r      <= pa;
              wdata_r     <= wt_data;
              busy_r      <= 1'b1;
              bus_req_r   <= 1'b1;
              bus_we_r    <= 1'b0;
              bus_addr_r  <= pa;
              bus_wdata_r <= 8'h00;
            end
            KIND_WR: begin
              state_r     <= WR;
              base_r      <= pa;
              wdata_r     <= wt_data;
              busy_r      <= 1'b1;
              bus_req_r   <= 1'b1;
              bus_we_r    <= 1'b1;
              bus_addr_r  <= pa;
              bus_wdata_r <= wt_data;
            end
            default: begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          endcase
        end

        LINE: begin
          if (fail_s) begin
            state_r     <= ERR;
            bus_error_r <= 1'b1;
            bus_req_r   <= 1'b0;
            bus_addr_r  <= {ADDR_WIDTH{1'b0}};
          end else if (ack_s) begin
            line_data_r  <= bus.bus_rdata;
            addr_count_r <= beat_r;
            line_write_r <= 1'b1;
            if (beat_r == BEAT_LAST) begin
              // Last write lands together with the completion pulses.
              state_r     <= DONE;
              beat_r      <= BEAT_ZERO;
              trans_rdy_r <= 1'b1;
              refill_r    <= 1'b1;
              bus_req_r   <= 1'b0;
              bus_addr_r  <= {ADDR_WIDTH{1'b0}};
            end else begin
              beat_r     <= beat_nxt_s;
              bus_addr_r <= {base_r[ADDR_WIDTH-1:LINE_WID], beat_nxt_s};
            end
          end else begin
            state_r <= LINE;
          end
        end

        RD: begin
          if (fail_s) begin
            state_r     <= ERR;
            bus_error_r <= 1'b1;
            bus_req_r   <= 1'b0;
            bus_addr_r  <= {ADDR_WIDTH{1'b0}};
          end else if (ack_s) begin
            state_r     <= DONE;
            line_data_r <= bus.bus_rdata;
            trans_rdy_r <= 1'b1;
            bus_req_r   <= 1'b0;
            bus_addr_r  <= {ADDR_WIDTH{1'b0}};
          end else begin
            state_r <= RD;
          end
        end

        WR: begin
          if (fail_s) begin
            state_r     <= ERR;
            bus_error_r <= 1'b1;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= {ADDR_WIDTH{1'b0}};
            bus_wdata_r <= 8'h00;
          end else if (ack_s) begin
            state_r     <= DONE;
            trans_rdy_r <= 1'b1;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= {ADDR_WIDTH{1'b0}};
            bus_wdata_r <= 8'h00;
          end else begin
            state_r <= WR;
          end
        end

        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          beat_r  <= BEAT_ZERO;
        end

        ERR: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          beat_r  <= BEAT_ZERO;
        end

        default: begin
          state_r     <= IDLE;
          busy_r      <= 1'b0;
          beat_r      <= BEAT_ZERO;
          bus_req_r   <= 1'b0;
          bus_we_r    <= 1'b0;
          bus_addr_r  <= {ADDR_WIDTH{1'b0}};
          bus_wdata_r <= 8'h00;
        end
      endcase
    end
  end

  assign line_data          = line_data_r;
  assign addr_count         = addr_count_r;
  assign line_write         = line_write_r;
  assign cache_entry_refill = refill_r;
  assign trans_rdy          = trans_rdy_r;
  assign bus_error          = bus_error_r;
  assign busy               = busy_r;

  assign bus.bus_req   = bus_req_r;
  assign bus.bus_we    = bus_we_r;
  assign bus.bus_addr  = bus_addr_r;
  assign bus.bus_wdata = bus_wdata_r;

endmodule

// File: tb/tb_l1_biu_seq.sv
// ---------------------------------------------------------------------------
// tb_l1_biu_seq
// Directed bench for l1_biu_seq (ADDR_WIDTH=24, LINE_WID=8, TIMEOUT_CYC=8).
// A small memory model answers the bus; each scenario task drives its
// stimulus on the falling edge and checks outputs on the falling edge.
// ---------------------------------------------------------------------------
module tb_l1_biu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_line_req;
  logic        read_req;
  logic        write_through_req;
  logic [23:0] pa;
  logic [7:0]  wt_data;
  logic [7:0]  line_data;
  logic [7:0]  addr_count;
  logic        line_write;
  logic        cache_entry_refill;
  logic        trans_rdy;
  logic        bus_error;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // Bus responder controls.
  logic        ack_en;
  int          ack_wait;
  logic        err_en;
  logic [7:0]  err_beat;
  logic        force_err;
  logic        use_fixed;
  logic [7:0]  fixed_rdata;
  int          wait_cnt = 0;

  l1_biu_seq_if #(.ADDR_WIDTH(24)) bif ();

  l1_biu_seq #(
    .ADDR_WIDTH  (24),
    .LINE_WID    (8),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .read_line_req      (read_line_req),
    .read_req           (read_req),
    .write_through_req  (write_through_req),
    .pa                 (pa),
    .wt_data            (wt_data),
    .line_data          (line_data),
    .addr_count         (addr_count),
    .line_write         (line_write),
    .cache_entry_refill (cache_entry_refill),
    .trans_rdy          (trans_rdy),
    .bus_error          (bus_error),
    .busy               (busy),
    .bus                (bif)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // Cycles the current beat has been waiting.
  always @(posedge clk) begin
    if (!bif.bus_req || bif.bus_ack || bif.bus_err) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  assign bif.bus_ack   = bif.bus_req && ack_en && (wait_cnt >= ack_wait);
  assign bif.bus_err   = bif.bus_req && (force_err ||
                         (err_en && (bif.bus_addr[7:0] == err_beat) && (wait_cnt >= ack_wait)));
  assign bif.bus_rdata = use_fixed ? fixed_rdata : mem_byte(bif.bus_addr);

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_cycles(3);
    checks++;
    if ({busy, bif.bus_req, line_write, trans_rdy, cache_entry_refill, bus_error} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {busy, bif.bus_req, line_write, trans_rdy, cache_entry_refill, bus_error});
    end
    checks++;
    if ({line_data, addr_count} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0000", {line_data, addr_count});
    end
    checks++;
    if ({bif.bus_we, bif.bus_addr, bif.bus_wdata} !== 33'h0) begin
      errors++;
      $display("FAIL reset_bus: got %h expected 0", {bif.bus_we, bif.bus_addr, bif.bus_wdata});
    end
    rst = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_line_refill();
    int lw_n = 0, addr_bad = 0, data_bad = 0, tr_n = 0, tr_at = -10, refill_n = 0;
    logic refill_at_tr = 1'b0;
    logic busy_after = 1'b1;
    pa = 24'h012345;
    read_line_req = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      read_line_req = 1'b0;
      if (bif.bus_req && (bif.bus_addr !== (24'h012300 + 24'(n - 1)))) addr_bad++;
      if (line_write) begin
        if (addr_count !== 8'(lw_n)) addr_bad++;
        if (line_data !== mem_byte({16'h0123, addr_count})) data_bad++;
        lw_n++;
      end
      if (trans_rdy) begin
        tr_n++;
        tr_at = n;
        refill_at_tr = cache_entry_refill;
      end
      if (cache_entry_refill) refill_n++;
      if (n == tr_at + 1) busy_after = busy;
    end
    checks++;
    if (addr_bad !== 0) begin errors++; $display("FAIL line_addr: got %0d bad expected 0", addr_bad); end
    checks++;
    if (data_bad !== 0) begin errors++; $display("FAIL line_data: got %0d bad expected 0", data_bad); end
    checks++;
    if (lw_n !== 256) begin errors++; $display("FAIL line_writes: got %0d expected 256", lw_n); end
    checks++;
    if (tr_at !== 257) begin errors++; $display("FAIL line_latency: got %0d expected 257", tr_at); end
    checks++;
    if (tr_n !== 1 || refill_n !== 1 || refill_at_tr !== 1'b1) begin
      errors++;
      $display("FAIL line_pulses: got tr=%0d refill=%0d coincide=%b expected 1 1 1",
               tr_n, refill_n, refill_at_tr);
    end
    checks++;
    if (busy_after !== 1'b0) begin errors++; $display("FAIL line_busy_after: got %b expected 0", busy_after); end
  endtask

  task automatic test_single_read();
    int lw_n = 0, refill_n = 0, tr_n = 0, tr_at = -1;
    logic [7:0] data_at_tr = 8'h00;
    logic [24:0] first_bus = 25'h0;
    use_fixed = 1'b1;
    fixed_rdata = 8'h5A;
    ack_wait = 3;
    pa = 24'h00ABCD;
    read_req = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      read_req = 1'b0;
      pa = 24'h111111;
      if (n == 1) first_bus = {bif.bus_we, bif.bus_addr};
      if (line_write) lw_n++;
      if (cache_entry_refill) refill_n++;
      if (trans_rdy) begin tr_n++; tr_at = n; data_at_tr = line_data; end
    end
    checks++;
    if (first_bus !== {1'b0, 24'h00ABCD}) begin
      errors++; $display("FAIL rd_bus: got %h expected %h", first_bus, {1'b0, 24'h00ABCD});
    end
    checks++;
    if (data_at_tr !== 8'h5A) begin errors++; $display("FAIL rd_data: got %h expected 5a", data_at_tr); end
    checks++;
    if (tr_n !== 1 || tr_at !== 5) begin
      errors++; $display("FAIL rd_trans_rdy: got n=%0d at=%0d expected 1 at 5", tr_n, tr_at);
    end
    checks++;
    if (lw_n !== 0 || refill_n !== 0) begin
      errors++; $display("FAIL rd_no_write: got lw=%0d refill=%0d expected 0 0", lw_n, refill_n);
    end
    use_fixed = 1'b0;
    ack_wait = 0;
  endtask

  task automatic test_write_through();
    int bad = 0, beats = 0, tr_n = 0, tr_at = -1, lw_n = 0;
    ack_wait = 4;
    pa = 24'h000010;
    wt_data = 8'hC3;
    write_through_req = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      write_through_req = 1'b0;
      wt_data = 8'hFF;
      pa = 24'h00FFFF;
      if (bif.bus_req) begin
        if (bif.bus_we !== 1'b1 || bif.bus_wdata !== 8'hC3 || bif.bus_addr !== 24'h000010) bad++;
        if (bif.bus_ack) beats++;
      end
      if (line_write) lw_n++;
      if (trans_rdy) begin tr_n++; tr_at = n; end
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL wr_bus: got %0d bad cycles expected 0", bad); end
    checks++;
    if (beats !== 1) begin errors++; $display("FAIL wr_beats: got %0d expected 1", beats); end
    checks++;
    if (tr_n !== 1 || tr_at !== 6) begin
      errors++; $display("FAIL wr_trans_rdy: got n=%0d at=%0d expected 1 at 6", tr_n, tr_at);
    end
    checks++;
    if (lw_n !== 0) begin errors++; $display("FAIL wr_no_line_write: got %0d expected 0", lw_n); end
    ack_wait = 0;
  endtask

  task automatic test_line_error();
    int lw_n = 0, be_n = 0, tr_n = 0, refill_n = 0;
    logic req_at_err = 1'b1;
    logic [23:0] first_addr = 24'h0;
    err_en = 1'b1;
    err_beat = 8'd17;
    pa = 24'h034567;
    read_line_req = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      read_line_req = 1'b0;
      if (line_write) lw_n++;
      if (trans_rdy) tr_n++;
      if (cache_entry_refill) refill_n++;
      if (bus_error) begin be_n++; req_at_err = bif.bus_req; end
    end
    checks++;
    if (lw_n !== 17) begin errors++; $display("FAIL err_line_writes: got %0d expected 17", lw_n); end
    checks++;
    if (be_n !== 1 || req_at_err !== 1'b0) begin
      errors++; $display("FAIL err_pulse: got n=%0d req=%b expected 1 0", be_n, req_at_err);
    end
    checks++;
    if (tr_n !== 0 || refill_n !== 0) begin
      errors++; $display("FAIL err_no_done: got tr=%0d refill=%0d expected 0 0", tr_n, refill_n);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL err_idle: got busy=%b expected 0", busy); end
    // A fresh refill must restart at beat 0 and finish cleanly.
    err_en = 1'b0;
    lw_n = 0;
    tr_n = 0;
    pa = 24'h0345FF;
    read_line_req = 1'b1;
    for (int n = 1; n <= 270; n++) begin
      @(negedge clk);
      read_line_req = 1'b0;
      if (n == 1) first_addr = bif.bus_addr;
      if (line_write) lw_n++;
      if (trans_rdy) tr_n++;
    end
    checks++;
    if (first_addr !== 24'h034500) begin
      errors++; $display("FAIL err_restart_addr: got %h expected 034500", first_addr);
    end
    checks++;
    if (lw_n !== 256 || tr_n !== 1) begin
      errors++; $display("FAIL err_restart_done: got lw=%0d tr=%0d expected 256 1", lw_n, tr_n);
    end
  endtask

  task automatic test_priority_and_reset();
    int pulses = 0;
    pa = 24'h056789;
    wt_data = 8'h11;
    read_line_req = 1'b1;
    write_through_req = 1'b1;
    @(negedge clk);
    read_line_req = 1'b0;
    write_through_req = 1'b0;
    checks++;
    if ({bif.bus_req, bif.bus_we, bif.bus_addr} !== {2'b10, 24'h056700}) begin
      errors++;
      $display("FAIL prio_line_first: got %h expected %h",
               {bif.bus_req, bif.bus_we, bif.bus_addr}, {2'b10, 24'h056700});
    end
    idle_cycles(10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, bif.bus_req, line_write, trans_rdy, cache_entry_refill, bus_error, bif.bus_we} !== 7'b0 ||
        {line_data, addr_count, bif.bus_addr} !== 40'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got flags=%b data=%h expected 0",
               {busy, bif.bus_req, line_write, trans_rdy, cache_entry_refill, bus_error, bif.bus_we},
               {line_data, addr_count, bif.bus_addr});
    end
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (trans_rdy || bus_error || cache_entry_refill || bif.bus_req || line_write) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL midreset_quiet: got %0d active cycles expected 0", pulses); end
  endtask

  task automatic test_timeout();
    ack_en = 1'b0;
    pa = 24'h000100;
    read_req = 1'b1;
`ifdef L1_BIU_TIMEOUT_EN
    begin
      int err_at = -1;
      for (int n = 1; n <= 30; n++) begin
        @(negedge clk);
        read_req = 1'b0;
        if (bus_error && err_at < 0) err_at = n;
      end
      checks++;
      if (err_at < 10 || err_at > 11) begin
        errors++; $display("FAIL timeout_abort: got bus_error at %0d expected 10..11", err_at);
      end
      checks++;
      if (busy !== 1'b0 || bif.bus_req !== 1'b0) begin
        errors++; $display("FAIL timeout_idle: got busy=%b req=%b expected 0 0", busy, bif.bus_req);
      end
    end
`else
    begin
      int low_n = 0, be_n = 0;
      for (int n = 1; n <= 40; n++) begin
        @(negedge clk);
        read_req = 1'b0;
        if (!bif.bus_req) low_n++;
        if (bus_error) be_n++;
      end
      checks++;
      if (low_n !== 0 || be_n !== 0) begin
        errors++; $display("FAIL no_timeout_wait: got low=%0d err=%0d expected 0 0", low_n, be_n);
      end
      force_err = 1'b1;
      @(negedge clk);
      force_err = 1'b0;
      checks++;
      if (bus_error !== 1'b1 || bif.bus_req !== 1'b0) begin
        errors++; $display("FAIL no_timeout_err_exit: got err=%b req=%b expected 1 0", bus_error, bif.bus_req);
      end
      idle_cycles(2);
    end
`endif
    ack_en = 1'b1;
    idle_cycles(2);
  endtask

  initial begin
    rst = 1'b1;
    read_line_req = 1'b0;
    read_req = 1'b0;
    write_through_req = 1'b0;
    pa = 24'h0;
    wt_data = 8'h0;
    ack_en = 1'b1;
    ack_wait = 0;
    err_en = 1'b0;
    err_beat = 8'h0;
    force_err = 1'b0;
    use_fixed = 1'b0;
    fixed_rdata = 8'h0;
    @(negedge clk);
    test_reset();
    test_line_refill();
    test_single_read();
    test_write_through();
    test_line_error();
    test_priority_and_reset();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
